// File: rtl/fetch_pc_stage_pkg.sv
// Shared types for the instruction-fetch PC stage: word type, fetch FSM
// states and the record presented to decode.
package fetch_pc_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  pred_taken;
    word_t pred_target;
  } fetch_out_t;

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Predictor lookup, instruction-memory request/response, execute redirect
// and decode output bundle. master = fetch stage, slave = its environment.
interface fetch_pc_stage_if;
  import fetch_pc_stage_pkg::*;

  word_t bp_pc;
  logic  bp_predicted_outcome;
  word_t bp_predicted_target;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  logic  ex_redirect;
  word_t ex_redirect_pc;

  logic  out_ready;
  logic  out_valid;
  word_t out_instr;
  word_t out_pc;
  logic  out_pred_taken;
  word_t out_pred_target;

  modport master (
    output bp_pc, imem_req, imem_addr,
    output out_valid, out_instr, out_pc, out_pred_taken, out_pred_target,
    input  bp_predicted_outcome, bp_predicted_target,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  ex_redirect, ex_redirect_pc, out_ready
  );

  modport slave (
    input  bp_pc, imem_req, imem_addr,
    input  out_valid, out_instr, out_pc, out_pred_taken, out_pred_target,
    output bp_predicted_outcome, bp_predicted_target,
    output imem_gnt, imem_rvalid, imem_rdata,
    output ex_redirect, ex_redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_pc_stage.sv
// Fetch PC stage: one outstanding imem request, next PC steered by the
// same-cycle predictor result, redirect flush, one-entry output slot.
//
// state | meaning
// IDLE  | nothing outstanding, may issue
// WAIT  | granted, response will be delivered to decode
// DRAIN | granted, response will be discarded (redirected meanwhile)
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter word_t RESET_PC    = 32'h0000_0000,
  parameter word_t INSTR_BYTES = 32'd4
) (
  input  logic              CLK,
  input  logic              RST,
  fetch_pc_stage_if.master  bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_pc_q, pend_pc_d;
  logic         pend_taken_q, pend_taken_d;
  word_t        pend_target_q, pend_target_d;
  logic         out_valid_q, out_valid_d;
  fetch_out_t   out_q, out_d;

  logic can_issue;
  logic req;
  logic grant;

  always_comb begin
    can_issue = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.ex_redirect;
    // Flops are held in reset while RST is high, so the request must be gated too.
    req       = can_issue && !RST;
    grant     = req && bus.imem_gnt;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    out_valid_d   = out_valid_q;
    out_d         = out_q;

    if (bus.ex_redirect) begin
      pc_d        = bus.ex_redirect_pc;
      out_valid_d = 1'b0;
      if (state_q != IDLE) begin
        state_d = bus.imem_rvalid ? IDLE : DRAIN;
      end
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            pend_pc_d     = pc_q;
            pend_taken_d  = bus.bp_predicted_outcome;
            pend_target_d = bus.bp_predicted_target;
            pc_d          = bus.bp_predicted_outcome ? bus.bp_predicted_target
                                                     : pc_q + INSTR_BYTES;
            state_d       = WAIT;
          end
        end
        WAIT: begin
          // Slot is free here: issue required it empty or draining.
          if (bus.imem_rvalid) begin
            out_valid_d = 1'b1;
            out_d       = '{instr:       bus.imem_rdata,
                            pc:          pend_pc_q,
                            pred_taken:  pend_taken_q,
                            pred_target: pend_target_q};
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          if (bus.imem_rvalid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= '0;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
    end
  end

  assign bus.bp_pc           = pc_q;
  assign bus.imem_req        = req;
  assign bus.imem_addr       = {pc_q[31:2], 2'b00};
  assign bus.out_valid       = out_valid_q;
  assign bus.out_instr       = out_q.instr;
  assign bus.out_pc          = out_q.pc;
  assign bus.out_pred_taken  = out_q.pred_taken;
  assign bus.out_pred_target = out_q.pred_target;

endmodule
